// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set definitions for the fetch unit: field widths, opcode and
// register codes, FSM state encoding and an opcode legality helper.
package fetch_unit_pkg;

  localparam int unsigned OPCODE_WIDTH      = 3;
  localparam int unsigned REG_WIDTH         = 2;
  localparam int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + REG_WIDTH;
  localparam int unsigned ADDR_WIDTH        = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST  = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd5;

  localparam logic [REG_WIDTH-1:0] REG_R0 = 2'd0;
  localparam logic [REG_WIDTH-1:0] REG_R1 = 2'd1;
  localparam logic [REG_WIDTH-1:0] REG_R2 = 2'd2;
  localparam logic [REG_WIDTH-1:0] REG_R3 = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue
  } fetch_state_e;

  // True for the six defined opcodes; everything else is flagged illegal.
  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_XOR: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fetch_unit_instr_decoder.sv
// instr_decoder: purely combinational split of an instruction word into opcode and
// register fields, plus legality check of the opcode.
module instr_decoder
  import fetch_unit_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] i_instr,
  output logic [OPCODE_WIDTH-1:0]      o_opcode,
  output logic [REG_WIDTH-1:0]         o_reg_sel,
  output logic                         o_illegal
);

  // Field extraction and legality lookup.
  always_comb begin
    o_opcode  = i_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    o_reg_sel = i_instr[REG_WIDTH-1:0];
    o_illegal = !is_legal_op(o_opcode);
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/ISSUE sequencer that reads an instruction ROM at the PC,
// latches the word and offers it to an executor with a valid/ready handshake.
// Optional build macro FETCH_NOP_SKIP_EN: NOPs are consumed in FETCH and never issued.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 5'd1,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 5'd31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [REG_WIDTH-1:0]         reg_sel,
  output logic                         instr_valid,
  input  logic                         exec_ready,
  output logic                         illegal,
  output logic                         busy
);

  fetch_state_e                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]        r_pc, w_pc_nxt;
  logic [INSTRUCTION_WIDTH-1:0] r_ir, w_ir_nxt;
  logic                         r_stop_pend, w_stop_nxt;
  logic                         w_dec_illegal;

  // PC increments and wraps from END_ADDR back to START_ADDR, skipping lower addresses.
  function automatic logic [ADDR_WIDTH-1:0] f_next_pc(input logic [ADDR_WIDTH-1:0] pc);
    logic [ADDR_WIDTH-1:0] nxt;
    if (pc == END_ADDR) nxt = START_ADDR;
    else                nxt = pc + 1'b1;
    return nxt;
  endfunction

  instr_decoder u_instr_decoder (
    .i_instr   (r_ir),
    .o_opcode  (opcode),
    .o_reg_sel (reg_sel),
    .o_illegal (w_dec_illegal)
  );

  // Next-state logic: sequencing, PC advance, instruction latch and stop bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    // A stop pulse seen this cycle counts the same as one remembered earlier.
    w_stop_nxt  = r_stop_pend | stop;
    unique case (r_state)
      StIdle: begin
        w_stop_nxt = 1'b0;
        if (start && !stop) w_state_nxt = StFetch;
      end
      StFetch: begin
        if (w_stop_nxt) begin
          // PC still names the unfetched word, so a later start resumes there.
          w_state_nxt = StIdle;
          w_stop_nxt  = 1'b0;
        end
`ifdef FETCH_NOP_SKIP_EN
        else if (rom_data[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == OP_NOP) begin
          w_pc_nxt = f_next_pc(r_pc);
        end
`endif
        else begin
          w_ir_nxt    = rom_data;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (exec_ready) begin
          w_pc_nxt = f_next_pc(r_pc);
          if (w_stop_nxt) begin
            w_state_nxt = StIdle;
            w_stop_nxt  = 1'b0;
          end else begin
            w_state_nxt = StFetch;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  // State registers; async reset drops instr_valid immediately via r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pc        <= START_ADDR;
      r_ir        <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_stop_pend <= w_stop_nxt;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    rom_addr    = r_pc;
    instr_valid = (r_state == StIssue);
    illegal     = (r_state == StIssue) && w_dec_illegal;
    busy        = (r_state != StIdle);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Build with FETCH_NOP_SKIP_EN defined to
// exercise the NOP-skip variant; expected issue sequences follow the build.
module tb_fetch_unit;

  localparam logic [2:0] T_NOP = 3'd0;
  localparam logic [2:0] T_LD  = 3'd1;
  localparam logic [2:0] T_ST  = 3'd2;
  localparam logic [2:0] T_ADD = 3'd3;
  localparam logic [2:0] T_SUB = 3'd4;
  localparam logic [2:0] T_XOR = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [4:0] rom_addr;
  logic [4:0] rom_data;
  logic [2:0] opcode;
  logic [1:0] reg_sel;
  logic       instr_valid;
  logic       exec_ready;
  logic       illegal;
  logic       busy;

  logic [4:0] rom [32];
  int checks   = 0;
  int failures = 0;

  logic [2:0] q_op   [$];
  logic [4:0] q_addr [$];
  logic       q_ill  [$];

  assign rom_data = rom[rom_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .opcode      (opcode),
    .reg_sel     (reg_sel),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] mk(input logic [2:0] op, input logic [1:0] r);
    return {op, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (rom_addr !== 5'd1) begin failures++;
      $display("FAIL reset_addr: got %0d expected 1", rom_addr); end
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || illegal !== 1'b0) begin failures++;
      $display("FAIL reset_flags: busy=%b valid=%b illegal=%b expected 0", busy, instr_valid,
               illegal); end
    rst_n = 1'b1;
    tick();
    checks++; if (rom_addr !== 5'd1 || busy !== 1'b0 || instr_valid !== 1'b0) begin failures++;
      $display("FAIL release: addr=%0d busy=%b valid=%b expected 1/0/0", rom_addr, busy,
               instr_valid); end
  endtask

  task automatic test_program();
    exec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 5'd1) begin failures++;
      $display("FAIL fetch1: busy=%b valid=%b addr=%0d expected 1/0/1", busy, instr_valid,
               rom_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || opcode !== T_LD || reg_sel !== 2'd3 ||
                  illegal !== 1'b0) begin failures++;
      $display("FAIL issue_ld: valid=%b op=%0d reg=%0d ill=%b expected 1/1/3/0", instr_valid,
               opcode, reg_sel, illegal); end
    tick();
    checks++; if (instr_valid !== 1'b0 || rom_addr !== 5'd2) begin failures++;
      $display("FAIL fetch2: valid=%b addr=%0d expected 0/2", instr_valid, rom_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || opcode !== T_ST || reg_sel !== 2'd2) begin failures++;
      $display("FAIL issue_st: valid=%b op=%0d reg=%0d expected 1/2/2", instr_valid, opcode,
               reg_sel); end
    tick();
    tick();
    checks++; if (instr_valid !== 1'b1 || opcode !== T_ADD || reg_sel !== 2'd2 ||
                  rom_addr !== 5'd3) begin failures++;
      $display("FAIL issue_add: valid=%b op=%0d reg=%0d addr=%0d expected 1/3/2/3",
               instr_valid, opcode, reg_sel, rom_addr); end
    tick();
  endtask

  task automatic test_stall();
    exec_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || opcode !== T_SUB || reg_sel !== 2'd3 ||
                    rom_addr !== 5'd4) begin failures++;
        $display("FAIL stall[%0d]: valid=%b op=%0d reg=%0d addr=%0d expected 1/4/3/4", i,
                 instr_valid, opcode, reg_sel, rom_addr); end
    end
  endtask

  task automatic test_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (instr_valid !== 1'b1 || rom_addr !== 5'd4) begin failures++;
      $display("FAIL stop_pending: valid=%b addr=%0d expected 1/4", instr_valid, rom_addr); end
    exec_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 5'd5) begin failures++;
      $display("FAIL stop_idle: busy=%b valid=%b addr=%0d expected 0/0/5", busy, instr_valid,
               rom_addr); end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (busy !== 1'b0 || rom_addr !== 5'd5) begin failures++;
      $display("FAIL start_stop_same: busy=%b addr=%0d expected 0/5", busy, rom_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 5'd5) begin failures++;
      $display("FAIL restart: busy=%b valid=%b addr=%0d expected 1/0/5", busy, instr_valid,
               rom_addr); end
  endtask

  task automatic test_wrap();
    bit done = 0;
    bit wrap_pending = 0;
    int wraps = 0;
    int ill_count = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (wrap_pending) begin
        wrap_pending = 0;
        wraps++;
        checks++; if (rom_addr !== 5'd1) begin failures++;
          $display("FAIL wrap_addr: got %0d expected 1", rom_addr); end
      end
      if (instr_valid) begin
        q_op.push_back(opcode);
        q_addr.push_back(rom_addr);
        q_ill.push_back(illegal);
        if (illegal) ill_count++;
        if (rom_addr == 5'd31) wrap_pending = 1;
        if (rom_addr == 5'd1) done = 1;
      end
      tick();
    end
    checks++; if (!done) begin failures++;
      $display("FAIL wrap_timeout: got no issue at address 1 expected one within 200 cycles");
    end
`ifdef FETCH_NOP_SKIP_EN
    checks++; if (q_op.size() !== 3) begin failures++;
      $display("FAIL skip_count: got %0d issues expected 3", q_op.size()); end
    else begin
      checks++; if (q_op[0] !== T_XOR || q_op[1] !== T_ADD || q_op[2] !== T_LD) begin
        failures++;
        $display("FAIL skip_order: got %0d,%0d,%0d expected 5,3,1", q_op[0], q_op[1],
                 q_op[2]); end
      checks++; if (q_addr[0] !== 5'd6 || q_addr[2] !== 5'd1) begin failures++;
        $display("FAIL skip_addr: got %0d,%0d expected 6,1", q_addr[0], q_addr[2]); end
    end
    checks++; if (wraps !== 0 || ill_count !== 0) begin failures++;
      $display("FAIL skip_flags: wraps=%0d ill=%0d expected 0/0", wraps, ill_count); end
`else
    checks++; if (q_op.size() !== 28) begin failures++;
      $display("FAIL run_count: got %0d issues expected 28", q_op.size()); end
    else begin
      checks++; if (q_op[0] !== T_NOP || q_addr[0] !== 5'd5 || q_op[1] !== T_XOR ||
                    q_op[2] !== T_ADD) begin failures++;
        $display("FAIL run_head: got %0d@%0d,%0d,%0d expected 0@5,5,3", q_op[0], q_addr[0],
                 q_op[1], q_op[2]); end
      checks++; if (q_op[25] !== T_ILL || q_ill[25] !== 1'b1 || q_addr[25] !== 5'd30) begin
        failures++;
        $display("FAIL illegal_issue: got op=%0d ill=%b addr=%0d expected 7/1/30", q_op[25],
                 q_ill[25], q_addr[25]); end
      checks++; if (q_op[27] !== T_LD || q_addr[27] !== 5'd1 || q_op[26] !== T_NOP) begin
        failures++;
        $display("FAIL run_tail: got %0d,%0d@%0d expected 0,1@1", q_op[26], q_op[27],
                 q_addr[27]); end
    end
    checks++; if (wraps !== 1 || ill_count !== 1) begin failures++;
      $display("FAIL run_flags: wraps=%0d ill=%0d expected 1/1", wraps, ill_count); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    exec_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || opcode !== T_ST || rom_addr !== 5'd2) begin
      failures++;
      $display("FAIL pre_reset_issue: valid=%b op=%0d addr=%0d expected 1/2/2", instr_valid,
               opcode, rom_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 5'd1 ||
                  illegal !== 1'b0) begin failures++;
      $display("FAIL async_reset: valid=%b busy=%b addr=%0d ill=%b expected 0/0/1/0",
               instr_valid, busy, rom_addr, illegal); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || rom_addr !== 5'd1) begin failures++;
      $display("FAIL post_reset: busy=%b addr=%0d expected 0/1", busy, rom_addr); end
  endtask

  initial begin
    start      = 1'b0;
    stop       = 1'b0;
    exec_ready = 1'b1;
    rst_n      = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = mk(T_NOP, 2'd0);
    rom[0] = 5'h1f;
    rom[1] = mk(T_LD, 2'd3);
    rom[2] = mk(T_ST, 2'd2);
    rom[3] = mk(T_ADD, 2'd2);
    rom[4] = mk(T_SUB, 2'd3);
    rom[5] = mk(T_NOP, 2'd0);
    rom[6] = mk(T_XOR, 2'd1);
    rom[7] = mk(T_ADD, 2'd0);
`ifndef FETCH_NOP_SKIP_EN
    rom[30] = mk(T_ILL, 2'd1);
`endif
    test_reset();
    test_program();
    test_stall();
    test_stop();
    test_wrap();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
